// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and default constants for the debounce array
//
// Purpose: debounce FSM state encoding and default parameter values used by
//          debounce_channel and debounce_array.
// Ports:   none (package).
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_ON_CHANGE = 2'b00,
    CHANGE_STATE   = 2'b01
  } state_e;

  localparam int DEFAULT_NUM_CH          = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_TIME   = 1000;
  localparam int DEFAULT_LONG_PRESS_TIME = 50000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input channel: synchronizer, debounce FSM, edge and long-press pulses
//
// Purpose: conditions a single raw asynchronous input into a clean registered
//          level with 1-cycle rise/fall pulses and an optional long-press pulse.
// Config:  DEBOUNCE_ARRAY_LONG_PRESS_EN builds the hold counter; otherwise
//          long_press_o is tied to 0.
// Ports:
//   clk           in   clock, all logic on posedge
//   reset         in   asynchronous active-high reset
//   button_i      in   raw asynchronous input
//   debounced_o   out  debounced level (registered)
//   rise_o        out  1-cycle pulse when debounced_o goes 0->1
//   fall_o        out  1-cycle pulse when debounced_o goes 1->0
//   long_press_o  out  1-cycle pulse when a press has been held LONG_PRESS_TIME cycles
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_TIME   = DEFAULT_DEBOUNCE_TIME,
  parameter int LONG_PRESS_TIME = DEFAULT_LONG_PRESS_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TIME);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   mismatch;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mismatch = sync ^ deb_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= WAIT_ON_CHANGE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], button_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = WAIT_ON_CHANGE;
    case (state_q)
      WAIT_ON_CHANGE: state_d = mismatch ? CHANGE_STATE : WAIT_ON_CHANGE;
      CHANGE_STATE:   state_d = (mismatch && (cnt_q != CNT_MAX)) ? CHANGE_STATE : WAIT_ON_CHANGE;
      default:        state_d = WAIT_ON_CHANGE;
    endcase
  end

  // Output / datapath logic. A match in CHANGE_STATE only aborts; the counter
  // is left alone because WAIT_ON_CHANGE clears it on the next mismatch.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    case (state_q)
      WAIT_ON_CHANGE: begin
        if (mismatch) cnt_d = '0;
      end
      CHANGE_STATE: begin
        if (mismatch) begin
          if (cnt_q == CNT_MAX) deb_d = sync;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: deb_d = 1'b0;
    endcase
    // Registered alongside deb_q so the pulse lines up with the level change
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  assign debounced_o = deb_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

`ifdef DEBOUNCE_ARRAY_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_TIME + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_TIME);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Saturating hold counter; the pulse fires only on the step into saturation,
  // so a single press can never repeat it.
  always_comb begin
    hold_d = hold_q;
    if (!deb_q)                 hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
    long_d = deb_q && (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press_o = long_q;
`else
  logic unused_long_time;
  assign unused_long_time = (LONG_PRESS_TIME == 0);
  assign long_press_o     = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - NUM_CH independent input debouncers with edge and long-press pulses
//
// Purpose: multi-channel input conditioner; each channel is a debounce_channel.
// Config:  DEBOUNCE_ARRAY_LONG_PRESS_EN enables long-press detection; when
//          undefined long_press is tied to 0 (port list unchanged).
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   asynchronous active-high reset
//   button_in      in   [NUM_CH] raw asynchronous inputs
//   debounced_out  out  [NUM_CH] debounced levels
//   rise_pulse     out  [NUM_CH] 1-cycle pulse on debounced 0->1
//   fall_pulse     out  [NUM_CH] 1-cycle pulse on debounced 1->0
//   long_press     out  [NUM_CH] 1-cycle pulse per press held LONG_PRESS_TIME cycles
module debounce_array
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = DEFAULT_NUM_CH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_TIME   = DEFAULT_DEBOUNCE_TIME,
  parameter int LONG_PRESS_TIME = DEFAULT_LONG_PRESS_TIME
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] debounced_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] long_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TIME  (DEBOUNCE_TIME),
      .LONG_PRESS_TIME(LONG_PRESS_TIME)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .button_i    (button_in[i]),
      .debounced_o (debounced_out[i]),
      .rise_o      (rise_pulse[i]),
      .fall_o      (fall_pulse[i]),
      .long_press_o(long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - directed self-checking bench for debounce_array
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button_in;
  logic [3:0] debounced_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] long_press;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_ARRAY_LONG_PRESS_EN
  localparam logic [3:0] LP_EXP = 4'h4;
`else
  localparam logic [3:0] LP_EXP = 4'h0;
`endif

  always #5 clk = ~clk;

  debounce_array #(
    .NUM_CH         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_TIME  (4),
    .LONG_PRESS_TIME(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .debounced_out(debounced_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .long_press   (long_press)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each step ends on a falling edge, away from the active edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [3:0] seen;

  initial begin
    reset     = 1'b0;
    button_in = 4'hF;

    // 1: asynchronous reset with all inputs high
    #1 reset = 1'b1;
    #1;
    check("rst_deb",  debounced_out, 4'h0);
    check("rst_rise", rise_pulse,    4'h0);
    check("rst_fall", fall_pulse,    4'h0);
    check("rst_long", long_press,    4'h0);
    @(negedge clk);
    tick(2);
    reset = 1'b0;
    tick(7);
    check("post_rst_e7_deb", debounced_out, 4'h0);
    tick(1);
    check("post_rst_e8_deb",  debounced_out, 4'hF);
    check("post_rst_e8_rise", rise_pulse,    4'hF);
    tick(1);
    check("post_rst_e9_rise", rise_pulse,    4'h0);
    button_in = 4'h0;
    tick(7);
    check("all_fall_e7_deb", debounced_out, 4'hF);
    tick(1);
    check("all_fall_e8_deb",  debounced_out, 4'h0);
    check("all_fall_e8_fall", fall_pulse,    4'hF);
    tick(1);
    check("all_fall_e9_fall", fall_pulse,    4'h0);

    // 2: channel 0 press, latency 8 edges
    button_in = 4'h1;
    tick(7);
    check("ch0_e7_deb",  debounced_out, 4'h0);
    check("ch0_e7_rise", rise_pulse,    4'h0);
    tick(1);
    check("ch0_e8_deb",  debounced_out, 4'h1);
    check("ch0_e8_rise", rise_pulse,    4'h1);
    tick(1);
    check("ch0_e9_rise", rise_pulse,    4'h0);
    check("ch0_e9_deb",  debounced_out, 4'h1);
    button_in = 4'h0;
    tick(8);
    check("ch0_rel_deb",  debounced_out, 4'h0);
    check("ch0_rel_fall", fall_pulse,    4'h1);
    tick(2);

    // 3: 5-cycle glitch is filtered, 6-cycle pulse is accepted
    button_in = 4'h2;
    tick(5);
    button_in = 4'h0;
    seen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | debounced_out | rise_pulse | fall_pulse;
    end
    check("glitch5_filtered", seen, 4'h0);
    button_in = 4'h2;
    tick(6);
    button_in = 4'h0;
    tick(2);
    check("pulse6_deb",  debounced_out, 4'h2);
    check("pulse6_rise", rise_pulse,    4'h2);
    tick(5);
    check("pulse6_e13_deb", debounced_out, 4'h2);
    tick(1);
    check("pulse6_e14_deb",  debounced_out, 4'h0);
    check("pulse6_e14_fall", fall_pulse,    4'h2);
    tick(2);

    // 4: channels 2 and 3 together
    button_in = 4'hC;
    tick(7);
    check("ch23_e7_deb", debounced_out, 4'h0);
    tick(1);
    check("ch23_e8_deb",  debounced_out, 4'hC);
    check("ch23_e8_rise", rise_pulse,    4'hC);
    tick(2);
    button_in = 4'h0;
    tick(7);
    check("ch23_rel_e7_deb", debounced_out, 4'hC);
    tick(1);
    check("ch23_rel_e8_deb",  debounced_out, 4'h0);
    check("ch23_rel_e8_fall", fall_pulse,    4'hC);
    tick(2);

    // 5: reset mid-debounce (counter at 3) discards progress
    button_in = 4'h1;
    tick(6);
    reset = 1'b1;
    #1;
    check("mid_rst_deb", debounced_out, 4'h0);
    @(negedge clk);
    tick(2);
    check("mid_rst_hold_deb", debounced_out, 4'h0);
    reset = 1'b0;
    tick(7);
    check("mid_rst_e7_deb", debounced_out, 4'h0);
    tick(1);
    check("mid_rst_e8_deb",  debounced_out, 4'h1);
    check("mid_rst_e8_rise", rise_pulse,    4'h1);
    button_in = 4'h0;
    tick(10);
    check("mid_rst_rel_deb", debounced_out, 4'h0);

    // 6: long press on channel 2
    button_in = 4'h4;
    tick(8);
    check("lp_rise", rise_pulse, 4'h4);
    tick(19);
    check("lp_before", long_press, 4'h0);
    tick(1);
    check("lp_fire", long_press, LP_EXP);
    seen = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | long_press;
    end
    check("lp_no_repeat", seen, 4'h0);
    check("lp_still_high", debounced_out, 4'h4);
    button_in = 4'h0;
    tick(8);
    check("lp_rel_deb", debounced_out, 4'h0);
    check("lp_rel_fall", fall_pulse, 4'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
